// File: rtl/regfile_pkg.sv
// Shared definitions for the register file write-port arbiter.
// Register numbers, default sizing, FSM states and grant sources.
package regfile_pkg;

    localparam logic [4:0] REG_K0           = 5'd26;
    localparam logic [4:0] UART_REG1_DEF    = 5'd16;
    localparam logic [4:0] UART_REG2_DEF    = 5'd17;
    localparam int         UART_DEPTH_DEF   = 4;
    localparam int         STARVE_LIMIT_DEF = 8;

    typedef enum logic [1:0] {
        NORMAL,
        EXC_PEND,
        STARVE
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_EXC,
        GNT_UART
    } gnt_src_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Small synchronous FIFO holding tagged UART bytes.
// Push and pop may coincide at any fill level, including full.
module uart_byte_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage array; head is read combinationally before any overwrite.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between WB, the $k0 exception
// save and buffered UART bytes; all writes leave through registers.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int         UART_DEPTH   = UART_DEPTH_DEF,
    parameter logic [4:0] UART_REG1    = UART_REG1_DEF,
    parameter logic [4:0] UART_REG2    = UART_REG2_DEF,
    parameter int         STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        exc_req,
    input  logic [31:0] exc_pc,
    input  logic        uart_valid,
    input  logic        uart_flag,
    input  logic [7:0]  uart_data,
    output logic        uart_ready,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data,
    output logic        stall_req,
    output logic        exc_done,
    output logic        uart_overflow
);

    localparam int CW = $clog2(UART_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(UART_DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_e       state;
    arb_state_e       state_next;
    gnt_src_e         gnt;
    logic             wb_req;
    logic             latch_pc;
    logic [31:0]      pend_pc;
    logic [31:0]      save_pc;
    logic [SW-1:0]    starve_cnt;
    logic             starve_full;
    logic             push;
    logic             pop;
    logic [8:0]       head;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic [4:0]       wr_addr;
    logic [31:0]      wr_data;

    assign wb_req      = wb_we && (wb_addr != 5'd0);
    assign starve_full = (starve_cnt == STARVE_MAX);
    assign uart_ready  = (count != FULL_CNT);
    assign pop         = (gnt == GNT_UART);
    assign push        = uart_valid && (!full || pop);

    uart_byte_fifo #(
        .WIDTH (9),
        .DEPTH (UART_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({uart_flag, uart_data}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Grant selection and next state: WB, then exception save, then UART.
    always_comb begin
        gnt        = GNT_NONE;
        state_next = state;
        latch_pc   = 1'b0;
        save_pc    = exc_pc;
        if (wb_req) begin
            gnt = GNT_WB;
        end else if (state == EXC_PEND) begin
            gnt     = GNT_EXC;
            save_pc = pend_pc;
        end else if (exc_req) begin
            gnt = GNT_EXC;
        end else if (!empty) begin
            gnt = GNT_UART;
        end
        unique case (state)
            NORMAL: begin
                if (exc_req && wb_req) begin
                    state_next = EXC_PEND;
                    latch_pc   = 1'b1;
                end else if (starve_full && !empty && gnt != GNT_UART) begin
                    state_next = STARVE;
                end
            end
            EXC_PEND: begin
                if (!wb_req) state_next = NORMAL;
            end
            STARVE: begin
                if (exc_req && wb_req) begin
                    state_next = EXC_PEND;
                    latch_pc   = 1'b1;
                end else if (gnt == GNT_UART) begin
                    state_next = NORMAL;
                end
            end
            default: state_next = NORMAL;
        endcase
    end

    // Write address/data mux for the granted source.
    always_comb begin
        wr_addr = 5'd0;
        wr_data = 32'd0;
        unique case (gnt)
            GNT_WB: begin
                wr_addr = wb_addr;
                wr_data = wb_data;
            end
            GNT_EXC: begin
                wr_addr = REG_K0;
                wr_data = save_pc;
            end
            GNT_UART: begin
                wr_addr = head[8] ? UART_REG2 : UART_REG1;
                wr_data = {24'd0, head[7:0]};
            end
            default: begin
                wr_addr = 5'd0;
                wr_data = 32'd0;
            end
        endcase
    end

    // FSM state, pending save PC and starvation counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= NORMAL;
            pend_pc    <= 32'd0;
            starve_cnt <= '0;
        end else begin
            state <= state_next;
            if (latch_pc) pend_pc <= exc_pc;
            if (pop) begin
                starve_cnt <= '0;
            end else if (!empty && !starve_full) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // Registered write port, status pulses and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we         <= 1'b0;
            rf_addr       <= 5'd0;
            rf_data       <= 32'd0;
            stall_req     <= 1'b0;
            exc_done      <= 1'b0;
            uart_overflow <= 1'b0;
        end else begin
            rf_we     <= (gnt != GNT_NONE);
            rf_addr   <= wr_addr;
            rf_data   <= wr_data;
            stall_req <= (state_next != NORMAL);
            exc_done  <= (gnt == GNT_EXC);
            if (uart_valid && full && !pop) uart_overflow <= 1'b1;
        end
    end

endmodule
